uart_rx: RTL and testbench

UART receiver, the RX counterpart feeding the memory-mapped UART register block (RX data at $C000, RX Ready at status bit 1).
- Samples the asynchronous rx pin at 16x baud, deframes 8N1 characters LSB first, and holds each byte in a one-deep output register until the CPU side acknowledges it.
- Reports framing errors and overruns as sticky flags.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, baud divisor rounding and
// the mid-bit sample indices used for the three-sample majority vote.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Clock cycles per oversample tick, rounded to the nearest integer.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return (clk_freq + (baud_rate * oversample) / 2) / (baud_rate * oversample);
    endfunction

    // First, centre and last sample index of the mid-bit vote window.
    function automatic int unsigned vote_first(input int unsigned oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int unsigned vote_mid(input int unsigned oversample);
        return oversample / 2;
    endfunction

    function automatic int unsigned vote_last(input int unsigned oversample);
        return oversample / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every DIV clocks,
// with a synchronous restart that realigns the phase to an external event.
module uart_baud_tick #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1, wrapping; restart forces the count back to zero.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled, majority-voted bits, one-deep output
// register with ack handshake, sticky framing and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    input  logic       err_clr
);

    localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_V0   = SW'(vote_first(OVERSAMPLE));
    localparam logic [SW-1:0] S_V1   = SW'(vote_mid(OVERSAMPLE));
    localparam logic [SW-1:0] S_V2   = SW'(vote_last(OVERSAMPLE));
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    logic rx_meta, rxs, rxs_d;
    logic tick, restart, vote;
    logic deliver, frame_set;

    rx_state_t state, state_next;
    logic [SW-1:0] s, s_next;
    logic [2:0] bit_idx, bit_idx_next;
    logic [7:0] shift, shift_next;
    logic v0, v0_next, v1, v1_next;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign vote = (v0 & v1) | (v0 & rxs) | (v1 & rxs);

    // FSM and bit datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s       <= '0;
            bit_idx <= '0;
            shift   <= '0;
            v0      <= 1'b0;
            v1      <= 1'b0;
        end else begin
            state   <= state_next;
            s       <= s_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            v0      <= v0_next;
            v1      <= v1_next;
        end
    end

    // Next-state logic: sample counting, mid-bit vote and frame sequencing.
    always_comb begin
        state_next   = state;
        s_next       = s;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        v0_next      = v0;
        v1_next      = v1;
        restart      = 1'b0;
        deliver      = 1'b0;
        frame_set    = 1'b0;

        if (state != IDLE && tick) begin
            s_next = (s == S_LAST) ? '0 : s + 1'b1;
            if (s == S_V0) v0_next = rxs;
            if (s == S_V1) v1_next = rxs;
        end

        case (state)
            IDLE: begin
                // Only a 1->0 transition starts a frame; a held-low line never retriggers.
                if (rxs_d && !rxs) begin
                    state_next = START;
                    s_next     = '0;
                    restart    = 1'b1;
                end
            end
            START: begin
                if (tick && s == S_V2 && vote) begin
                    state_next = IDLE;
                end else if (tick && s == S_LAST) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (tick && s == S_V2) begin
                    shift_next = {vote, shift[7:1]};
                end
                if (tick && s == S_LAST) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (tick && s == S_V2) begin
                    deliver    = vote;
                    frame_set  = !vote;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output holding register, ack handshake and sticky error flags (set wins over clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            if (deliver) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
            rx_frame_err <= frame_set || (rx_frame_err && !err_clr);
            rx_overrun   <= (deliver && rx_valid && !rx_ack) || (rx_overrun && !err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 1.6 MHz / 10 kbaud / 16x (160 clk per bit).
module tb_uart_rx;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       err_clr;

    int n_checks = 0;
    int n_pass   = 0;
    int rise_at;
    int lat;
    bit dropped;

    uart_rx #(
        .CLK_FREQ  (1600000),
        .BAUD_RATE (10000),
        .OVERSAMPLE(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drives nbits frame bits (start, 8 data LSB first, stop) from a negedge,
    // optionally pulsing rx_ack at cycle ack_at; records the cycle rx_valid rises.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int nbits, input int ack_at);
        logic [9:0] f;
        logic       prev;
        int         k;
        f       = {stop_bit, b, 1'b0};
        rise_at = -1;
        dropped = 1'b0;
        prev    = rx_valid;
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < BIT_CLKS; c++) begin
                k      = i * BIT_CLKS + c;
                rx     = f[i];
                rx_ack = (k == ack_at);
                @(negedge clk);
                if (rise_at < 0 && rx_valid && !prev) rise_at = k + 1;
                if (prev && !rx_valid) dropped = 1'b1;
                prev = rx_valid;
            end
        end
        rx_ack = 1'b0;
        rx     = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse(input string tag);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        check(tag, rx_valid, 0);
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        rx_ack  = 1'b0;
        err_clr = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_ferr", rx_frame_err, 0);
        check("rst_ovr", rx_overrun, 0);
        idle(50);

        // 1: plain byte, latency, ack clears valid
        send_frame(8'h55, 1'b1, 10, -1);
        lat = rise_at;
        check("t1_data", rx_data, 32'h55);
        check("t1_valid", rx_valid, 1);
        check("t1_latency", (lat >= 1515 && lat <= 1560), 1);
        check("t1_ferr", rx_frame_err, 0);
        check("t1_ovr", rx_overrun, 0);
        ack_pulse("t1_ack_clear");
        idle(20);

        // 2: 40-clk glitch is rejected, following byte received
        rx = 1'b0;
        repeat (40) @(negedge clk);
        idle(200);
        check("t2_glitch_valid", rx_valid, 0);
        check("t2_glitch_ferr", rx_frame_err, 0);
        send_frame(8'hA3, 1'b1, 10, -1);
        check("t2_data", rx_data, 32'hA3);
        check("t2_valid", rx_valid, 1);
        ack_pulse("t2_ack_clear");
        idle(20);

        // 3: framing error, recovery, err_clr
        send_frame(8'h0F, 1'b0, 10, -1);
        check("t3_bad_valid", rx_valid, 0);
        check("t3_ferr_set", rx_frame_err, 1);
        idle(BIT_CLKS);
        send_frame(8'h3C, 1'b1, 10, -1);
        check("t3_data", rx_data, 32'h3C);
        check("t3_valid", rx_valid, 1);
        check("t3_ferr_sticky", rx_frame_err, 1);
        clr_pulse();
        check("t3_ferr_clr", rx_frame_err, 0);
        ack_pulse("t3_ack_clear");
        idle(20);

        // 4: overrun keeps old byte
        send_frame(8'h11, 1'b1, 10, -1);
        send_frame(8'h22, 1'b1, 10, -1);
        check("t4_data_kept", rx_data, 32'h11);
        check("t4_valid", rx_valid, 1);
        check("t4_ovr_set", rx_overrun, 1);
        ack_pulse("t4_ack_clear");
        send_frame(8'h33, 1'b1, 10, -1);
        check("t4_data_new", rx_data, 32'h33);
        check("t4_ovr_sticky", rx_overrun, 1);
        clr_pulse();
        check("t4_ovr_clr", rx_overrun, 0);
        ack_pulse("t4_ack_clear2");
        idle(20);

        // 5: ack coincident with delivery replaces byte, no overrun
        send_frame(8'h11, 1'b1, 10, -1);
        check("t5_first", rx_data, 32'h11);
        send_frame(8'h22, 1'b1, 10, (lat > 0) ? lat - 1 : 1542);
        check("t5_data", rx_data, 32'h22);
        check("t5_valid", rx_valid, 1);
        check("t5_no_drop", dropped, 0);
        check("t5_ovr", rx_overrun, 0);
        idle(20);

        // 6: reset mid-frame, then clean frame
        send_frame(8'hFF, 1'b1, 5, -1);
        rx  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_ferr", rx_frame_err, 0);
        check("t6_rst_ovr", rx_overrun, 0);
        idle(1000);
        check("t6_abandoned", rx_valid, 0);
        send_frame(8'hC3, 1'b1, 10, -1);
        check("t6_data", rx_data, 32'hC3);
        check("t6_valid", rx_valid, 1);
        check("t6_ferr", rx_frame_err, 0);
        check("t6_ovr", rx_overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
